puf_test_scheduler: RTL

//  Sequences multi-phase NIST randomness testing of the PUF response stream.
//  Per phase: runs N_ROUNDS rounds of N_BITS bits through the NIST block, tallies per-test passes,

---
 rtl/puf_test_scheduler_if.sv | 27 ++
 rtl/puf_test_scheduler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/puf_test_scheduler_if.sv
// Bundles the scheduler's host, PUF, NIST and result-memory signals.
// The scheduler uses the slave view; the host/NIST/memory side uses the master view.
interface puf_test_scheduler_if #(
    parameter int AW = 13
);
    logic          start;
    logic          resp_in;
    logic [7:0]    test_result;
    logic          test_data;
    logic          sel_clk_test;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_din;
    logic [1:0]    phase;
    logic          busy;
    logic          done;

    modport master (
        output start, resp_in, test_result,
        input  test_data, sel_clk_test, mem_we, mem_waddr, mem_din, phase, busy, done
    );

    modport slave (
        input  start, resp_in, test_result,
        output test_data, sel_clk_test, mem_we, mem_waddr, mem_din, phase, busy, done
    );
endinterface

// File: rtl/puf_test_scheduler.sv
// Multi-phase NIST test sequencer: streams PUF bits to the NIST block for
// N_ROUNDS rounds per phase, tallies per-test pass flags, then writes the
// tallies into result memory at address {phase, test}.
module puf_test_scheduler #(
    parameter int N_BITS   = 20000,
    parameter int N_ROUNDS = 255,
    parameter int N_PHASES = 3,
    parameter int N_TESTS  = 8,
    parameter int AW       = 13
) (
    input logic                 clk_1,
    input logic                 rst,
    puf_test_scheduler_if.slave bus
);

    localparam int BW = $clog2(N_BITS);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ACCUM,
        STORE,
        NEXT,
        DONE
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_bitCnt;
    logic [7:0]    r_roundCnt;
    logic [2:0]    r_idx;
    logic [1:0]    r_phase;
    logic [7:0]    r_tally [N_TESTS];
    logic          r_testData;
    logic          r_selClk;
    logic          r_memWe;
    logic [AW-1:0] r_memAddr;
    logic [7:0]    r_memDin;
    logic          r_busy;
    logic          r_done;

    logic [7:0]    w_tallySum [N_TESTS];
    logic [2:0]    w_idxNext;

    // Saturating per-test tally update, used at the end of every round
    for (genvar g = 0; g < N_TESTS; g++) begin : g_sum
        assign w_tallySum[g] = (r_tally[g] == 8'hFF) ? 8'hFF
                             : r_tally[g] + {7'd0, bus.test_result[g]};
    end

    assign w_idxNext = r_idx + 3'd1;

    // Campaign sequencer: all outputs are registered here
    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bitCnt   <= '0;
            r_roundCnt <= '0;
            r_idx      <= '0;
            r_phase    <= '0;
            r_testData <= 1'b0;
            r_selClk   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memDin   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < N_TESTS; i++) r_tally[i] <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_memWe <= 1'b0;
                    if (bus.start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_phase    <= '0;
                        r_selClk   <= 1'b0;
                        r_bitCnt   <= '0;
                        r_roundCnt <= '0;
                    end
                end
                RUN: begin
                    r_testData <= bus.resp_in;
                    r_bitCnt   <= r_bitCnt + BW'(1);
                    if (r_bitCnt == BW'(N_BITS - 1)) r_state <= ACCUM;
                end
                ACCUM: begin
                    r_testData <= bus.resp_in;
                    r_bitCnt   <= '0;
                    for (int i = 0; i < N_TESTS; i++) r_tally[i] <= w_tallySum[i];
                    if (r_roundCnt == 8'(N_ROUNDS - 1)) begin
                        r_roundCnt <= '0;
                        r_state    <= STORE;
                        r_idx      <= '0;
                        r_memWe    <= 1'b1;
                        r_memAddr  <= AW'({r_phase, 3'd0});
                        r_memDin   <= w_tallySum[0];
                    end else begin
                        r_roundCnt <= r_roundCnt + 8'd1;
                        r_state    <= RUN;
                    end
                end
                STORE: begin
                    r_testData <= bus.resp_in;
                    if (r_idx == 3'(N_TESTS - 1)) begin
                        r_state <= NEXT;
                        r_memWe <= 1'b0;
                    end else begin
                        r_idx     <= w_idxNext;
                        r_memAddr <= AW'({r_phase, w_idxNext});
                        r_memDin  <= r_tally[w_idxNext];
                    end
                end
                NEXT: begin
                    r_memWe <= 1'b0;
                    for (int i = 0; i < N_TESTS; i++) r_tally[i] <= '0;
                    if (r_phase == 2'(N_PHASES - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase    <= r_phase + 2'd1;
                        r_selClk   <= 1'b1;
                        r_state    <= RUN;
                        r_bitCnt   <= '0;
                        r_roundCnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.test_data    = r_testData;
    assign bus.sel_clk_test = r_selClk;
    assign bus.mem_we       = r_memWe;
    assign bus.mem_waddr    = r_memAddr;
    assign bus.mem_din      = r_memDin;
    assign bus.phase        = r_phase;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

endmodule
